// File: rtl/seg_scan_capture_if.sv
// Bundle between the seven-segment display driver (master) and the
// capture/readback block (slave).
interface seg_scan_capture_if #(
    parameter int NDIGITS = 4
);
    logic [6:0]           seg_n;
    logic [NDIGITS-1:0]   dig_sel;
    logic                 clr;
    logic [4*NDIGITS-1:0] digits_out;
    logic [NDIGITS-1:0]   invalid_out;
    logic                 frame_valid;
    logic                 err_multi;

    modport master (
        output seg_n, dig_sel, clr,
        input  digits_out, invalid_out, frame_valid, err_multi
    );

    modport slave (
        input  seg_n, dig_sel, clr,
        output digits_out, invalid_out, frame_valid, err_multi
    );
endinterface

// File: rtl/seg_scan_capture.sv
// Recovers the hex nibble shown on each digit of a multiplexed, active-low
// seven-segment bus once the bus has dwelt on one pattern long enough.
module seg_scan_capture #(
    parameter int NDIGITS        = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    seg_scan_capture_if.slave   bus,
    output logic                o_dbg_state
);
    // The bus is free-running: every edge samples it, there is no valid/ready
    // handshake and no backpressure; outputs are status levels and pulses.
    localparam int         SW      = NDIGITS + 7;
    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

    typedef enum logic {ST_WAIT, ST_HOLD} state_t;

    state_t               r_state;
    logic [SW-1:0]        r_sample_q;
    logic [7:0]           r_run;
    logic [NDIGITS-1:0]   r_seen;
    logic [4*NDIGITS-1:0] r_digits;
    logic [NDIGITS-1:0]   r_invalid;
    logic                 r_frame;
    logic                 r_err;

    logic [NDIGITS-1:0]   w_sel_norm;
    logic [SW-1:0]        w_sample_d;
    logic                 w_same;
    logic [7:0]           w_run_next;
    logic                 w_capture;
    logic [NDIGITS-1:0]   w_sel;
    logic [6:0]           w_lit;
    logic [3:0]           w_sel_cnt;
    logic                 w_valid;
    logic [3:0]           w_nibble;
    logic [NDIGITS-1:0]   w_seen_new;

    assign w_sel_norm = (DIG_ACTIVE_LOW != 0) ? ~bus.dig_sel : bus.dig_sel;
    assign w_sample_d = {w_sel_norm, bus.seg_n};
    // Compare the incoming sample with sample_q so the run length is known on
    // the same edge that completes it.
    assign w_same     = (w_sample_d == r_sample_q);
    assign w_run_next = !w_same ? 8'd1 :
                        (r_run == RUN_MAX) ? RUN_MAX : r_run + 8'd1;
    assign w_capture  = (r_state == ST_WAIT) && (w_run_next == RUN_MAX);
    assign w_sel      = r_sample_q[SW-1:7];
    assign w_lit      = ~r_sample_q[6:0];
    assign w_seen_new = r_seen | w_sel;

    always_comb begin
        w_sel_cnt = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            w_sel_cnt = w_sel_cnt + 4'(w_sel[i]);
        end
    end

    // Lit-segment mask (bit0=a .. bit6=g) to hex value.
    always_comb begin
        w_valid  = 1'b1;
        w_nibble = 4'h0;
        case (w_lit)
            7'h3F: w_nibble = 4'h0;
            7'h06: w_nibble = 4'h1;
            7'h5B: w_nibble = 4'h2;
            7'h4F: w_nibble = 4'h3;
            7'h66: w_nibble = 4'h4;
            7'h6D: w_nibble = 4'h5;
            7'h7D: w_nibble = 4'h6;
            7'h07: w_nibble = 4'h7;
            7'h7F: w_nibble = 4'h8;
            7'h6F: w_nibble = 4'h9;
            7'h77: w_nibble = 4'hA;
            7'h7C: w_nibble = 4'hB;
            7'h39: w_nibble = 4'hC;
            7'h5E: w_nibble = 4'hD;
            7'h79: w_nibble = 4'hE;
            7'h71: w_nibble = 4'hF;
            default: w_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_WAIT;
            r_sample_q <= '0;
            r_run      <= 8'd0;
            r_seen     <= '0;
            r_digits   <= '0;
            r_invalid  <= '1;
            r_frame    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_sample_q <= w_sample_d;
            r_run      <= w_run_next;
            r_frame    <= 1'b0;
            r_err      <= 1'b0;

            case (r_state)
                ST_WAIT: if (w_capture) r_state <= ST_HOLD;
                ST_HOLD: if (!w_same)   r_state <= ST_WAIT;
                default:                r_state <= ST_WAIT;
            endcase

            if (bus.clr) begin
                r_digits  <= '0;
                r_invalid <= '1;
                r_seen    <= '0;
            end else if (w_capture) begin
                if (w_sel_cnt > 4'd1) begin
                    r_err <= 1'b1;
                end else if (w_sel_cnt == 4'd1) begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (w_sel[i]) begin
                            if (w_valid) r_digits[4*i +: 4] <= w_nibble;
                            r_invalid[i] <= !w_valid;
                        end
                    end
                    if (w_seen_new == '1) begin
                        r_frame <= 1'b1;
                        r_seen  <= '0;
                    end else begin
                        r_seen  <= w_seen_new;
                    end
                end
            end
        end
    end

    assign bus.digits_out  = r_digits;
    assign bus.invalid_out = r_invalid;
    assign bus.frame_valid = r_frame;
    assign bus.err_multi   = r_err;
    assign o_dbg_state     = (r_state == ST_HOLD);
endmodule
